// File: rtl/head_icon_blitter_pkg.sv
// Shared constants for the snake head icon path: direction one-hot codes,
// blitter FSM encodings and default icon dimensions.
package head_icon_blitter_pkg;

  localparam int unsigned DIR_W          = 4;
  localparam int unsigned ICON_ADDR_W    = 7;
  localparam int unsigned PIXEL_W        = 16;
  localparam int unsigned DEFAULT_ICON_W = 10;
  localparam int unsigned DEFAULT_ICON_H = 10;

  localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_UP    = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b1000;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd1;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  // Any code that is not exactly one of the four headings falls back to DOWN.
  function automatic logic [DIR_W-1:0] sanitize_direction(input logic [DIR_W-1:0] dir);
    logic [DIR_W-1:0] result;
    case (dir)
      DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT: result = dir;
      default:                               result = DIR_DOWN;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/head_icon_scan_counter.sv
// Column/row raster counter for one icon, with a linear ROM address kept in
// step and a last-pixel flag. Wraps back to the origin after the last pixel.
module head_icon_scan_counter
  import head_icon_blitter_pkg::*;
#(
  parameter int unsigned ICON_W = DEFAULT_ICON_W,
  parameter int unsigned ICON_H = DEFAULT_ICON_H,
  parameter int unsigned COL_W  = (ICON_W > 1) ? $clog2(ICON_W) : 1,
  parameter int unsigned ROW_W  = (ICON_H > 1) ? $clog2(ICON_H) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  output logic [COL_W-1:0]       col,
  output logic [ROW_W-1:0]       row,
  output logic [ICON_ADDR_W-1:0] addr,
  output logic                   last_c
);

  logic col_end_c;

  assign col_end_c = (col == COL_W'(ICON_W - 1));
  assign last_c    = col_end_c && (row == ROW_W'(ICON_H - 1));

  // Raster advance: the address tracks row*ICON_W+col by simple increment.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_c) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (col_end_c) begin
        col  <= '0;
        row  <= row + ROW_W'(1);
        addr <= addr + ICON_ADDR_W'(1);
      end else begin
        col  <= col + COL_W'(1);
        addr <= addr + ICON_ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/head_icon_blitter.sv
// Snake head icon blitter: fetches one icon from the rotator ROM bank pixel by
// pixel and streams it to the LCD pixel-write port at a latched origin.
// Optional colour-key skipping is enabled with HEAD_ICON_TRANSPARENCY_EN.
module head_icon_blitter
  import head_icon_blitter_pkg::*;
#(
  parameter int unsigned         ICON_W             = DEFAULT_ICON_W,
  parameter int unsigned         ICON_H             = DEFAULT_ICON_H,
  parameter int unsigned         X_W                = 8,
  parameter int unsigned         Y_W                = 9,
  parameter int unsigned         SETTLE_CYCLES      = 2,
  parameter logic [PIXEL_W-1:0]  TRANSPARENT_COLOUR = 16'hF81F
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIR_W-1:0]       direction,
  input  logic [X_W-1:0]         originX,
  input  logic [Y_W-1:0]         originY,
  output logic                   busy,
  output logic                   done,
  output logic [DIR_W-1:0]       iconDirection,
  output logic [ICON_ADDR_W-1:0] iconAddress,
  input  logic [PIXEL_W-1:0]     iconData,
  output logic                   pixelWrite,
  output logic [X_W-1:0]         pixelX,
  output logic [Y_W-1:0]         pixelY,
  output logic [PIXEL_W-1:0]     pixelData,
  input  logic                   pixelReady
);

  localparam int unsigned COL_W       = (ICON_W > 1) ? $clog2(ICON_W) : 1;
  localparam int unsigned ROW_W       = (ICON_H > 1) ? $clog2(ICON_H) : 1;
  localparam int unsigned SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  logic [STATE_W-1:0]  state_q;
  logic [STATE_W-1:0]  state_next;
  logic [SETTLE_W-1:0] settle_cnt_q;
  logic [X_W-1:0]      origin_x_q;
  logic [Y_W-1:0]      origin_y_q;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                last_c;
  logic                settle_done_c;
  logic                scan_clear;
  logic                scan_advance;
  logic                capture;

  assign settle_done_c = (settle_cnt_q == SETTLE_W'(SETTLE_LAST));

`ifdef HEAD_ICON_TRANSPARENCY_EN
`else
  logic unused_key;
  assign unused_key = ^TRANSPARENT_COLOUR;
`endif

  head_icon_scan_counter #(
    .ICON_W (ICON_W),
    .ICON_H (ICON_H),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (scan_clear),
    .advance (scan_advance),
    .col     (col),
    .row     (row),
    .addr    (iconAddress),
    .last_c  (last_c)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_next   = state_q;
    scan_clear   = 1'b0;
    scan_advance = 1'b0;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scan_clear = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_done_c) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef HEAD_ICON_TRANSPARENCY_EN
        if (iconData == TRANSPARENT_COLOUR) begin
          scan_advance = 1'b1;
          state_next   = last_c ? ST_DONE : ST_FETCH;
        end else begin
          capture    = 1'b1;
          state_next = ST_WRITE;
        end
`else
        capture    = 1'b1;
        state_next = ST_WRITE;
`endif
      end
      ST_WRITE: begin
        if (pixelReady) begin
          scan_advance = 1'b1;
          state_next   = last_c ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, start-time latches and the settle timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pixelWrite    <= 1'b0;
      pixelX        <= '0;
      pixelY        <= '0;
      pixelData     <= '0;
      iconDirection <= DIR_DOWN;
      origin_x_q    <= '0;
      origin_y_q    <= '0;
      settle_cnt_q  <= '0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
      pixelWrite <= (state_next == ST_WRITE);

      settle_cnt_q <= (state_q == ST_SETTLE) ? settle_cnt_q + SETTLE_W'(1) : '0;

      if ((state_q == ST_IDLE) && start) begin
        origin_x_q    <= originX;
        origin_y_q    <= originY;
        iconDirection <= sanitize_direction(direction);
      end

      if (capture) begin
        pixelData <= iconData;
        pixelX    <= origin_x_q + X_W'(col);
        pixelY    <= origin_y_q + Y_W'(row);
      end
    end
  end

endmodule

// File: tb/tb_head_icon_blitter.sv
// Randomised bench for head_icon_blitter with a ROM model and a raster-order
// reference list of expected pixel writes.
module tb_head_icon_blitter;

  localparam int unsigned ICON_W        = 10;
  localparam int unsigned ICON_H        = 10;
  localparam int unsigned X_W           = 8;
  localparam int unsigned Y_W           = 9;
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned N_PIX         = ICON_W * ICON_H;
  localparam logic [15:0] KEY           = 16'hF81F;
`ifdef HEAD_ICON_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic           clock;
  logic           reset;
  logic           start;
  logic [3:0]     direction;
  logic [X_W-1:0] origin_x;
  logic [Y_W-1:0] origin_y;
  logic           busy;
  logic           done;
  logic [3:0]     icon_direction;
  logic [6:0]     icon_address;
  logic [15:0]    icon_data;
  logic           pixel_write;
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;
  logic [15:0]    pixel_data;
  logic           pixel_ready;

  logic [15:0] rom [128];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int start_cyc = 0;
  int got_base = 0;

  logic [X_W-1:0] got_x[$];
  logic [Y_W-1:0] got_y[$];
  logic [15:0]    got_d[$];
  logic [X_W-1:0] exp_x[$];
  logic [Y_W-1:0] exp_y[$];
  logic [15:0]    exp_d[$];

  head_icon_blitter #(
    .ICON_W             (ICON_W),
    .ICON_H             (ICON_H),
    .X_W                (X_W),
    .Y_W                (Y_W),
    .SETTLE_CYCLES      (SETTLE_CYCLES),
    .TRANSPARENT_COLOUR (KEY)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .direction     (direction),
    .originX       (origin_x),
    .originY       (origin_y),
    .busy          (busy),
    .done          (done),
    .iconDirection (icon_direction),
    .iconAddress   (icon_address),
    .iconData      (icon_data),
    .pixelWrite    (pixel_write),
    .pixelX        (pixel_x),
    .pixelY        (pixel_y),
    .pixelData     (pixel_data),
    .pixelReady    (pixel_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // One-cycle-latency icon ROM.
  always @(posedge clock) icon_data <= rom[icon_address];

  // Record every write the sink accepts on the coming edge.
  always @(negedge clock) begin
    if (pixel_write === 1'b1 && pixel_ready === 1'b1) begin
      got_x.push_back(pixel_x);
      got_y.push_back(pixel_y);
      got_d.push_back(pixel_data);
    end
    if (done === 1'b1) done_count = done_count + 1;
  end

  task automatic fill_rom();
    logic [15:0] w;
    for (int i = 0; i < 128; i++) begin
      w = 16'($urandom);
      if (w == KEY) w = w ^ 16'h0001;
      rom[i] = w;
    end
  endtask

  // Reference: raster order, origin plus offset modulo the coordinate width.
  task automatic build_expected(input int ox, input int oy);
    int idx;
    exp_x.delete();
    exp_y.delete();
    exp_d.delete();
    for (int r = 0; r < int'(ICON_H); r++) begin
      for (int c = 0; c < int'(ICON_W); c++) begin
        idx = r * int'(ICON_W) + c;
        if (!(TRANSP && rom[idx] == KEY)) begin
          exp_x.push_back(X_W'((ox + c) % 256));
          exp_y.push_back(Y_W'((oy + r) % 512));
          exp_d.push_back(rom[idx]);
        end
      end
    end
  endtask

  // Cycles from the start cycle to the done cycle: settle, 3 per written
  // pixel, 2 per skipped pixel, one for done, plus any sink stall.
  function automatic int expected_latency(input int stall);
    int written;
    written = exp_x.size();
    return int'(SETTLE_CYCLES) + 3 * written + 2 * (int'(N_PIX) - written) + 1 + stall;
  endfunction

  function automatic int list_errors();
    int errs;
    int n;
    errs = 0;
    n = got_x.size() - got_base;
    if (n != exp_x.size()) errs++;
    for (int i = 0; i < exp_x.size() && i < n; i++) begin
      if (got_x[got_base+i] !== exp_x[i] || got_y[got_base+i] !== exp_y[i] ||
          got_d[got_base+i] !== exp_d[i]) errs++;
    end
    return errs;
  endfunction

  function automatic logic [3:0] random_one_hot();
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  task automatic issue_start(input logic [3:0] dir, input int ox, input int oy);
    @(posedge clock);
    #1;
    start     = 1'b1;
    direction = dir;
    origin_x  = X_W'(ox);
    origin_y  = Y_W'(oy);
    start_cyc = cyc;
    got_base  = got_x.size();
    @(posedge clock);
    #1;
    start     = 1'b0;
    direction = 4'($urandom);
    origin_x  = X_W'($urandom);
    origin_y  = Y_W'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok, output int lat);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic wait_accepted(input int count, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (got_x.size() - got_base >= count) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    direction = 4'b0000;
    origin_x = '0;
    origin_y = '0;
    pixel_ready = 1'b1;
    fill_rom();
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (pixel_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b expected 0", pixel_write); end
    total++; if (icon_address !== 7'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", icon_address); end
    total++; if (icon_direction !== 4'b0001) begin bad++; $display("FAIL reset_dir: got %b expected 0001", icon_direction); end
    total++; if (pixel_x !== '0) begin bad++; $display("FAIL reset_x: got %0d expected 0", pixel_x); end
    total++; if (pixel_y !== '0) begin bad++; $display("FAIL reset_y: got %0d expected 0", pixel_y); end
    total++; if (pixel_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h expected 0000", pixel_data); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    int n;
    fill_rom();
    pixel_ready = 1'b1;
    build_expected(20, 30);
    issue_start(4'b0100, 20, 30);
    @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
    total++; if (icon_direction !== 4'b0100) begin bad++; $display("FAIL basic_dir: got %b expected 0100", icon_direction); end
    wait_done(2000, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done expected done"); end
    total++; if (lat != expected_latency(0)) begin bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, expected_latency(0)); end
    n = got_x.size() - got_base;
    total++; if (n != int'(N_PIX)) begin bad++; $display("FAIL basic_count: got %0d expected %0d", n, N_PIX); end
    total++;
    if ({got_x[got_base], got_y[got_base], got_d[got_base]} !== {X_W'(20), Y_W'(30), rom[0]}) begin
      bad++; $display("FAIL basic_first: got (%0d,%0d,%h) expected (20,30,%h)", got_x[got_base], got_y[got_base], got_d[got_base], rom[0]);
    end
    total++;
    if ({got_x[got_base+n-1], got_y[got_base+n-1], got_d[got_base+n-1]} !== {X_W'(29), Y_W'(39), rom[99]}) begin
      bad++; $display("FAIL basic_last: got (%0d,%0d,%h) expected (29,39,%h)", got_x[got_base+n-1], got_y[got_base+n-1], got_d[got_base+n-1], rom[99]);
    end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL basic_list: got %0d bad entries expected 0", list_errors()); end
    @(negedge clock);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    total++; if (icon_direction !== 4'b0100) begin bad++; $display("FAIL basic_dir_hold: got %b expected 0100", icon_direction); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    bit seen;
    fill_rom();
    pixel_ready = 1'b1;
    build_expected(20, 30);
    issue_start(random_one_hot(), 20, 30);
    wait_accepted(12, 1000);
    @(posedge clock);
    #1 pixel_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pixel_write === 1'b1) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_write_seen: got none expected pixel 12"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      total++;
      if ({pixel_write, pixel_x, pixel_y, pixel_data} !== {1'b1, X_W'(22), Y_W'(31), rom[12]}) begin
        bad++; $display("FAIL stall_hold_%0d: got w=%b (%0d,%0d,%h) expected w=1 (22,31,%h)", i, pixel_write, pixel_x, pixel_y, pixel_data, rom[12]);
      end
    end
    @(posedge clock);
    #1 pixel_ready = 1'b1;
    wait_done(2000, ok, lat);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no done expected done"); end
    total++; if (lat != expected_latency(5)) begin bad++; $display("FAIL stall_latency: got %0d expected %0d", lat, expected_latency(5)); end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL stall_list: got %0d bad entries expected 0", list_errors()); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int lat;
    int ox;
    int oy;
    int done_before;
    fill_rom();
    pixel_ready = 1'b1;
    ox = int'($urandom_range(0, 200));
    oy = int'($urandom_range(0, 400));
    build_expected(ox, oy);
    issue_start(4'b0100, ox, oy);
    wait_accepted(40, 1000);
    @(posedge clock);
    #1;
    done_before = done_count;
    start     = 1'b1;
    direction = 4'b1000;
    origin_x  = '0;
    origin_y  = '0;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    total++; if (icon_direction !== 4'b0100) begin bad++; $display("FAIL ignore_dir: got %b expected 0100", icon_direction); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    wait_done(2000, ok, lat);
    total++; if (lat != expected_latency(0)) begin bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat, expected_latency(0)); end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL ignore_list: got %0d bad entries expected 0", list_errors()); end
    repeat (5) @(posedge clock);
    #1;
    total++; if (done_count - done_before != 1) begin bad++; $display("FAIL ignore_done_count: got %0d expected 1", done_count - done_before); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue: got busy=%b expected 0", busy); end
  endtask

  task automatic test_bad_direction();
    bit ok;
    int lat;
    logic [3:0] dir;
    int ox;
    int oy;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) dir = 4'b0110;
      else begin
        dir = 4'($urandom);
        while ($countones(dir) == 1) dir = 4'($urandom);
      end
      fill_rom();
      ox = int'($urandom_range(0, 255));
      oy = int'($urandom_range(0, 511));
      build_expected(ox, oy);
      issue_start(dir, ox, oy);
      @(negedge clock);
      total++; if (icon_direction !== 4'b0001) begin bad++; $display("FAIL baddir_%b: got %b expected 0001", dir, icon_direction); end
      wait_done(2000, ok, lat);
      total++; if (list_errors() != 0) begin bad++; $display("FAIL baddir_list_%0d: got %0d bad entries expected 0", k, list_errors()); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int lat;
    int n;
    fill_rom();
    build_expected(250, 507);
    issue_start(random_one_hot(), 250, 507);
    wait_done(2000, ok, lat);
    n = got_x.size() - got_base;
    total++;
    if ({got_x[got_base+n-1], got_y[got_base+n-1], got_d[got_base+n-1]} !== {X_W'(3), Y_W'(4), rom[99]}) begin
      bad++; $display("FAIL wrap_last: got (%0d,%0d,%h) expected (3,4,%h)", got_x[got_base+n-1], got_y[got_base+n-1], got_d[got_base+n-1], rom[99]);
    end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL wrap_list: got %0d bad entries expected 0", list_errors()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int done_seen;
    int ox;
    int oy;
    fill_rom();
    pixel_ready = 1'b1;
    issue_start(4'b0010, 40, 50);
    wait_accepted(50, 1000);
    @(posedge clock);
    #1 pixel_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pixel_write === 1'b1) break;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pixel_ready = 1'b1;
    @(negedge clock);
    total++; if (pixel_write !== 1'b0) begin bad++; $display("FAIL rst_mid_write: got %b expected 0", pixel_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (icon_direction !== 4'b0001) begin bad++; $display("FAIL rst_mid_dir: got %b expected 0001", icon_direction); end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clock);
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_seen); end
    ox = int'($urandom_range(0, 255));
    oy = int'($urandom_range(0, 511));
    build_expected(ox, oy);
    issue_start(random_one_hot(), ox, oy);
    wait_done(2000, ok, lat);
    total++; if (lat != expected_latency(0)) begin bad++; $display("FAIL rst_redraw_latency: got %0d expected %0d", lat, expected_latency(0)); end
    total++; if (got_d[got_base] !== rom[0]) begin bad++; $display("FAIL rst_redraw_first: got %h expected %h", got_d[got_base], rom[0]); end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL rst_redraw_list: got %0d bad entries expected 0", list_errors()); end
  endtask

  task automatic test_transparency();
    bit ok;
    int lat;
    int n;
    int ox;
    int oy;
    fill_rom();
    for (int i = 0; i < 10; i++) rom[i] = KEY;
    pixel_ready = 1'b1;
    ox = int'($urandom_range(0, 255));
    oy = int'($urandom_range(0, 500));
    build_expected(ox, oy);
    issue_start(random_one_hot(), ox, oy);
    wait_done(2000, ok, lat);
    n = got_x.size() - got_base;
    total++; if (!ok) begin bad++; $display("FAIL key_done: got no done expected done"); end
    total++; if (n != exp_x.size()) begin bad++; $display("FAIL key_count: got %0d expected %0d", n, exp_x.size()); end
    total++; if (got_y[got_base] !== exp_y[0]) begin bad++; $display("FAIL key_first_row: got y=%0d expected %0d", got_y[got_base], exp_y[0]); end
    total++; if (lat != expected_latency(0)) begin bad++; $display("FAIL key_latency: got %0d expected %0d", lat, expected_latency(0)); end
    total++; if (list_errors() != 0) begin bad++; $display("FAIL key_list: got %0d bad entries expected 0", list_errors()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_bad_direction();
    test_wrap();
    test_reset_mid();
    test_transparency();
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
